// File: rtl/calc_pkg.sv
// Shared encodings and constants for the sign-magnitude calculator engine.
package calc_pkg;

  // Width of the decimal-limit arithmetic; operand width W must not exceed it.
  localparam int unsigned PowW = 128;

  typedef logic [1:0] op_t;
  localparam op_t OpAdd = 2'b00;
  localparam op_t OpSub = 2'b01;
  localparam op_t OpMul = 2'b10;
  localparam op_t OpDiv = 2'b11;

  typedef logic [1:0] err_t;
  localparam err_t ErrNone    = 2'b00;
  localparam err_t ErrOvf     = 2'b01;
  localparam err_t ErrDivZero = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t StIdle   = 3'd0;
  localparam state_t StAddSub = 3'd1;
  localparam state_t StMul    = 3'd2;
  localparam state_t StDiv    = 3'd3;
  localparam state_t StCheck  = 3'd4;

  function automatic logic [PowW-1:0] pow10(input int unsigned n);
    logic [PowW-1:0] r;
    r = PowW'(1);
    for (int unsigned i = 0; i < n; i++) begin
      r = r * PowW'(10);
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle for W cycles.
module calc_muldiv_iter #(
  parameter int unsigned W = 40
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_div,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic         o_ovf
);

  localparam int unsigned CntW = $clog2(W);

  logic            busy_q;
  logic            div_q;
  logic [CntW-1:0] cnt_q;
  // acc: product high half (MUL) or partial remainder (DIV); sh: multiplier/quotient shifter
  logic [W:0]      acc_q, acc_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    opnd_q;

  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W+1:0]    div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[W-1:0]} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[W-1:0], sh_q[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_q) begin
      if (!div_diff[W+1]) begin
        acc_d = div_diff[W:0];
        sh_d  = {sh_q[W-2:0], 1'b1};
      end else begin
        acc_d = div_shift;
        sh_d  = {sh_q[W-2:0], 1'b0};
      end
    end else begin
      acc_d = {1'b0, mul_sum[W:1]};
      sh_d  = {mul_sum[0], sh_q[W-1:1]};
    end
  end

  // Done flags the cycle in which the final step is taken; results are valid afterwards.
  assign o_done   = busy_q && (cnt_q == CntW'(W - 1));
  assign o_result = sh_q;
  assign o_ovf    = !div_q && (|acc_q);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
    end else if (i_start) begin
      busy_q <= 1'b1;
      div_q  <= i_div;
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= i_div ? i_a : i_b;
      opnd_q <= i_div ? i_b : i_a;
    end else if (busy_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_q + 1'b1;
      if (o_done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Sign-magnitude four-function calculator with decimal overflow limits and sticky error.
module calc_engine
  import calc_pkg::*;
#(
  parameter int unsigned W      = 40,
  parameter int unsigned DIGITS = 6
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_a_neg,
  input  logic         i_b_neg,
  input  logic         i_clear,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic         o_neg,
  output logic         o_err,
  output logic [1:0]   o_err_code
);

  localparam logic [PowW-1:0] PosLim = pow10(DIGITS) - PowW'(1);
  localparam logic [PowW-1:0] NegLim = pow10(DIGITS - 1) - PowW'(1);

  state_t       state_q, state_d;
  op_t          op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [W-1:0] mag_q, mag_d;
  logic         neg_q, neg_d, ovf_q, ovf_d, dz_q, dz_d;
  logic         done_q, done_d;
  logic [W-1:0] result_q, result_d;
  logic         res_neg_q, res_neg_d;
  logic         err_q, err_d;
  err_t         code_q, code_d;

  logic         accept, iter_start, iter_div, iter_done, iter_ovf;
  logic [W-1:0] iter_result;

  assign accept     = (state_q == StIdle) && i_start && !err_q;
  assign iter_div   = (i_op == OpDiv);
  assign iter_start = accept && (i_op == OpMul || (iter_div && i_b != '0));

  calc_muldiv_iter #(
    .W(W)
  ) u_iter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (iter_start),
    .i_div   (iter_div),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_done  (iter_done),
    .o_result(iter_result),
    .o_ovf   (iter_ovf)
  );

  // Signed-magnitude add: SUB flips the sign of b, then larger magnitude wins.
  logic         eff_b_neg;
  logic [W:0]   add_sum;
  logic [W-1:0] as_mag;
  logic         as_neg, as_ovf;

  always_comb begin
    eff_b_neg = b_neg_q ^ (op_q == OpSub);
    add_sum   = {1'b0, a_q} + {1'b0, b_q};
    as_ovf    = 1'b0;
    if (a_neg_q == eff_b_neg) begin
      as_mag = add_sum[W-1:0];
      as_neg = a_neg_q;
      as_ovf = add_sum[W];
    end else if (a_q >= b_q) begin
      as_mag = a_q - b_q;
      as_neg = a_neg_q;
    end else begin
      as_mag = b_q - a_q;
      as_neg = eff_b_neg;
    end
  end

  // MUL/DIV results stay held in the iterator after it finishes, so CHECK reads them directly.
  logic [W-1:0]    chk_mag;
  logic [PowW-1:0] chk_mag_ext;
  logic            chk_neg, chk_ovf, chk_err;

  always_comb begin
    chk_mag     = op_q[1] ? iter_result : mag_q;
    chk_neg     = op_q[1] ? (a_neg_q ^ b_neg_q) : neg_q;
    chk_mag_ext = PowW'(chk_mag);
    chk_ovf     = (op_q[1] ? iter_ovf : ovf_q) ||
                  (chk_mag_ext > (chk_neg ? NegLim : PosLim));
    chk_err     = dz_q || chk_ovf;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    result_d  = result_q;
    res_neg_d = res_neg_q;
    err_d     = err_q;
    code_d    = code_q;

    if (i_clear) begin
      err_d  = 1'b0;
      code_d = ErrNone;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = i_op;
          a_d     = i_a;
          b_d     = i_b;
          a_neg_d = i_a_neg;
          b_neg_d = i_b_neg;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          if (i_op == OpMul) begin
            state_d = StMul;
          end else if (i_op == OpDiv) begin
            state_d = StDiv;
          end else begin
            state_d = StAddSub;
          end
        end
      end
      StAddSub: begin
        mag_d   = as_mag;
        neg_d   = as_neg;
        ovf_d   = as_ovf;
        state_d = StCheck;
      end
      StMul: begin
        if (iter_done) begin
          state_d = StCheck;
        end
      end
      StDiv: begin
        if (b_q == '0) begin
          dz_d    = 1'b1;
          state_d = StCheck;
        end else if (iter_done) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (chk_err) begin
          result_d  = '0;
          res_neg_d = 1'b0;
          err_d     = 1'b1;
          code_d    = dz_q ? ErrDivZero : ErrOvf;
        end else begin
          result_d  = chk_mag;
          res_neg_d = chk_neg && (chk_mag != '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      op_q      <= OpAdd;
      a_q       <= '0;
      b_q       <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      res_neg_q <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ErrNone;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      result_q  <= result_d;
      res_neg_q <= res_neg_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign o_busy     = (state_q != StIdle);
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_neg      = res_neg_q;
  assign o_err      = err_q;
  assign o_err_code = code_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed and randomized checks of calc_engine against an arithmetic reference model.
module tb_calc_engine;

  localparam int unsigned W      = 40;
  localparam int unsigned DIGITS = 6;

  localparam logic [1:0] TAdd = 2'b00;
  localparam logic [1:0] TSub = 2'b01;
  localparam logic [1:0] TMul = 2'b10;
  localparam logic [1:0] TDiv = 2'b11;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [1:0]   i_op;
  logic [W-1:0] i_a, i_b;
  logic         i_a_neg, i_b_neg;
  logic         i_clear;
  logic         o_busy, o_done, o_neg, o_err;
  logic [W-1:0] o_result;
  logic [1:0]   o_err_code;

  int checks = 0;
  int errors = 0;

  calc_engine #(
    .W     (W),
    .DIGITS(DIGITS)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_a_neg   (i_a_neg),
    .i_b_neg   (i_b_neg),
    .i_clear   (i_clear),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result),
    .o_neg     (o_neg),
    .o_err     (o_err),
    .o_err_code(o_err_code)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic, then the decimal display limits.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic an,
                       input logic [W-1:0] b, input logic bn, output logic [W-1:0] r,
                       output logic rn, output logic [1:0] code, output int lat);
    longint     sa, sb, s, lim;
    logic [127:0] m;
    logic       neg;
    code = 2'b00;
    lat  = 3;
    neg  = 1'b0;
    m    = '0;
    if (op == TDiv && b == '0) begin
      code = 2'b10;
    end else if (op == TAdd || op == TSub) begin
      sa  = an ? -longint'(a) : longint'(a);
      sb  = (bn ^ (op == TSub)) ? -longint'(b) : longint'(b);
      s   = sa + sb;
      neg = (s < 0);
      m   = neg ? 128'(-s) : 128'(s);
    end else begin
      lat = W + 2;
      neg = an ^ bn;
      m   = (op == TMul) ? 128'(a) * 128'(b) : 128'(a / b);
    end
    if (m == 0) neg = 1'b0;
    lim = 1;
    for (int i = 0; i < (neg ? DIGITS - 1 : DIGITS); i++) lim = lim * 10;
    lim = lim - 1;
    if (code == 2'b00 && (m > 128'(lim) || m >= (128'(1) << W))) code = 2'b01;
    if (code != 2'b00) begin
      r  = '0;
      rn = 1'b0;
    end else begin
      r  = m[W-1:0];
      rn = neg;
    end
  endtask

  // mode 0: plain; 1: pulse i_start and i_clear mid-operation; 2: hold i_clear throughout
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic an,
                        input logic [W-1:0] b, input logic bn, input string tag,
                        input int mode);
    logic [W-1:0] er;
    logic         en;
    logic [1:0]   ec;
    int           lat, cyc;
    model(op, a, an, b, bn, er, en, ec, lat);
    @(negedge i_clk);
    i_op = op; i_a = a; i_a_neg = an; i_b = b; i_b_neg = bn; i_start = 1'b1;
    if (mode == 2) i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check({tag, "_busy"}, 64'(o_busy), 64'd1);
    // cyc = index of the cycle after the accepting edge
    cyc = 1;
    while (!o_done && cyc < 200) begin
      if (mode == 1 && cyc == 5) begin
        i_start = 1'b1; i_clear = 1'b1; i_op = TAdd; i_a = 1; i_b = 1;
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (mode != 2) i_clear = 1'b0;
      cyc++;
    end
    i_clear = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_result"}, 64'(o_result), 64'(er));
    check({tag, "_neg"}, 64'(o_neg), 64'(en));
    check({tag, "_err"}, 64'(o_err), 64'(ec != 2'b00));
    check({tag, "_code"}, 64'(o_err_code), 64'(ec));
    @(posedge i_clk); #1;
    check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    check({tag, "_hold"}, 64'(o_result), 64'(er));
  endtask

  task automatic do_clear(input string tag);
    @(negedge i_clk); i_clear = 1'b1;
    @(negedge i_clk); i_clear = 1'b0;
    check({tag, "_cleared"}, 64'({o_err, o_err_code}), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_mag();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0:       return W'($urandom_range(0, 999));
      1:       return W'($urandom_range(0, 1200000));
      2:       return v[W-1:0];
      3:       return W'($urandom_range(0, 1100));
      default: return '0;
    endcase
  endfunction

  initial begin
    logic         seen;
    logic [1:0]   rop;
    logic [W-1:0] big;
    i_reset = 1'b1; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0;
    i_a_neg = 1'b0; i_b_neg = 1'b0; i_clear = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", 64'({o_busy, o_done, o_neg, o_err, o_err_code}), 64'd0);
    check("reset_result", 64'(o_result), 64'd0);
    @(negedge i_clk); i_reset = 1'b0;

    run_op(TAdd, 123456, 1'b0, 23456, 1'b1, "add_mixed", 0);
    run_op(TSub, 5, 1'b0, 12, 1'b0, "sub_5_12", 0);
    run_op(TSub, 0, 1'b0, 100000, 1'b0, "sub_neg_ovf", 0);
    do_clear("sub_neg_ovf");
    run_op(TMul, 999, 1'b0, 1001, 1'b0, "mul_999999", 0);
    run_op(TMul, 1000, 1'b0, 1000, 1'b0, "mul_ovf", 0);

    // Sticky error blocks a new start until cleared
    @(negedge i_clk);
    i_op = TAdd; i_a = 1; i_b = 1; i_a_neg = 1'b0; i_b_neg = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    seen = o_busy | o_done;
    repeat (4) begin
      @(posedge i_clk); #1;
      seen = seen | o_busy | o_done;
    end
    check("err_blocks_start", 64'(seen), 64'd0);
    check("err_still_set", 64'({o_err, o_err_code}), 64'({1'b1, 2'b01}));
    check("err_result_zero", 64'(o_result), 64'd0);
    do_clear("mul_ovf");

    big = '0;
    big[W-1] = 1'b1;
    run_op(TMul, big, 1'b0, 4, 1'b0, "mul_wide_ovf", 0);
    do_clear("mul_wide_ovf");
    run_op(TDiv, 100, 1'b1, 7, 1'b0, "div_neg", 0);
    run_op(TDiv, 5, 1'b0, 0, 1'b0, "div_zero", 0);
    do_clear("div_zero");
    run_op(TMul, 3, 1'b1, 0, 1'b0, "mul_neg_zero", 1);
    run_op(TSub, 7, 1'b1, 7, 1'b1, "sub_to_zero", 0);
    run_op(TAdd, 999999, 1'b0, 1, 1'b0, "add_clear_ovf", 2);
    do_clear("add_clear_ovf");
    run_op(TAdd, 3, 1'b0, 4, 1'b0, "add_pre_reset", 0);

    // Asynchronous reset in the middle of a division
    @(negedge i_clk);
    i_op = TDiv; i_a = 1000; i_b = 3; i_a_neg = 1'b1; i_b_neg = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (19) @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    check("rst_mid_outputs", 64'({o_busy, o_done, o_neg, o_err, o_err_code}), 64'd0);
    check("rst_mid_result", 64'(o_result), 64'd0);
    @(negedge i_clk); i_reset = 1'b0;
    run_op(TAdd, 1, 1'b0, 1, 1'b0, "add_after_reset", 0);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      run_op(rop, rand_mag(), 1'($urandom_range(0, 1)), rand_mag(),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", n), 0);
      do_clear($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
